// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave):
// one valid/ready request channel and a valid-only read-response channel.
interface mem_stage_lsu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  dmem_req_valid;
    logic                  dmem_req_ready;
    logic                  dmem_req_we;
    logic [DATA_WIDTH-1:0] dmem_req_addr;
    logic [DATA_WIDTH-1:0] dmem_req_wdata;
    logic [STRB_WIDTH-1:0] dmem_req_wstrb;
    logic                  dmem_rsp_valid;
    logic [DATA_WIDTH-1:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid,
        input  dmem_req_ready,
        output dmem_req_we,
        output dmem_req_addr,
        output dmem_req_wdata,
        output dmem_req_wstrb,
        input  dmem_rsp_valid,
        input  dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid,
        output dmem_req_ready,
        input  dmem_req_we,
        input  dmem_req_addr,
        input  dmem_req_wdata,
        input  dmem_req_wstrb,
        output dmem_rsp_valid,
        output dmem_rsp_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: one bus transaction per load/store, pipeline stalled until it completes.
// Optional macro LSU_MISALIGN_TRAP_EN adds misalign_fault_MEM and skips misaligned requests.
module mem_stage_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead_MEM,
    input  logic                  MemWrite_MEM,
    input  logic [DATA_WIDTH-1:0] alu_result_MEM,
    input  logic [DATA_WIDTH-1:0] rd_data2_MEM,
    input  logic [DATA_WIDTH-1:0] instruction_MEM,
    mem_stage_lsu_if.master       dmem,
    output logic                  stall_MEM,
    output logic                  mem_done_MEM,
    output logic [DATA_WIDTH-1:0] load_data_MEM
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_fault_MEM
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    state_e                state_d, state_q;
    size_e                 size_d, size_q, size_in;
    logic                  we_d, we_q;
    logic                  sext_d, sext_q;
    logic [1:0]            lane_d, lane_q;
    logic [DATA_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_d, wstrb_q;
    logic [DATA_WIDTH-1:0] load_data_d, load_data_q;

    logic [2:0]            funct3;
    logic                  access;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [STRB_WIDTH-1:0] store_wstrb;
    logic [DATA_WIDTH-1:0] rsp_byte_sh, rsp_half_sh, rsp_fmt;
    logic                  unused_instr;

    assign funct3       = instruction_MEM[14:12];
    assign access       = MemRead_MEM | MemWrite_MEM;
    assign unused_instr = ^{instruction_MEM[DATA_WIDTH-1:15], instruction_MEM[11:0]};

    // Stores decode only SB/SH explicitly; loads ignore funct3[2], which selects zero-extension.
    always_comb begin
        size_in = SzWord;
        if (MemWrite_MEM) begin
            if (funct3 == 3'b000) begin
                size_in = SzByte;
            end else if (funct3 == 3'b001) begin
                size_in = SzHalf;
            end
        end else begin
            if (funct3[1:0] == 2'b00) begin
                size_in = SzByte;
            end else if (funct3[1:0] == 2'b01) begin
                size_in = SzHalf;
            end
        end
    end

    always_comb begin
        store_wdata = rd_data2_MEM;
        store_wstrb = '1;
        unique case (size_in)
            SzByte: begin
                store_wdata = {STRB_WIDTH{rd_data2_MEM[7:0]}};
                store_wstrb = STRB_WIDTH'(1) << alu_result_MEM[1:0];
            end
            SzHalf: begin
                store_wdata = {(STRB_WIDTH / 2){rd_data2_MEM[15:0]}};
                store_wstrb = STRB_WIDTH'(2'b11) << {alu_result_MEM[1], 1'b0};
            end
            default: begin
                store_wdata = rd_data2_MEM;
                store_wstrb = '1;
            end
        endcase
    end

    assign rsp_byte_sh = dmem.dmem_rsp_rdata >> {lane_q, 3'b000};
    assign rsp_half_sh = dmem.dmem_rsp_rdata >> {lane_q[1], 4'b0000};

    always_comb begin
        rsp_fmt = dmem.dmem_rsp_rdata;
        unique case (size_q)
            SzByte: rsp_fmt = {{(DATA_WIDTH - 8){sext_q & rsp_byte_sh[7]}}, rsp_byte_sh[7:0]};
            SzHalf: rsp_fmt = {{(DATA_WIDTH - 16){sext_q & rsp_half_sh[15]}}, rsp_half_sh[15:0]};
            default: rsp_fmt = dmem.dmem_rsp_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_d, misalign_q;

    assign misaligned = ((size_in == SzHalf) && alu_result_MEM[0]) ||
                        ((size_in == SzWord) && (alu_result_MEM[1:0] != 2'b00));
`endif

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        we_d        = we_q;
        sext_d      = sext_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        load_data_d = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    we_d    = MemWrite_MEM;
                    size_d  = size_in;
                    sext_d  = ~funct3[2];
                    lane_d  = alu_result_MEM[1:0];
                    addr_d  = {alu_result_MEM[DATA_WIDTH-1:2], 2'b00};
                    wdata_d = store_wdata;
                    wstrb_d = MemWrite_MEM ? store_wstrb : '0;
                    state_d = StReq;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = StDone;
                    end
`endif
                end
            end
            StReq: begin
                if (dmem.dmem_req_ready) begin
                    state_d = we_q ? StDone : StResp;
                end
            end
            StResp: begin
                if (dmem.dmem_rsp_valid) begin
                    load_data_d = rsp_fmt;
                    state_d     = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            size_q      <= SzWord;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            lane_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            we_q        <= we_d;
            sext_q      <= sext_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign dmem.dmem_req_valid = (state_q == StReq);
    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_wdata = wdata_q;
    assign dmem.dmem_req_wstrb = wstrb_q;
    assign mem_done_MEM        = (state_q == StDone);
    // In IDLE the stall must rise in the same cycle the access appears in EX/MEM.
    assign stall_MEM           = (state_q == StIdle) ? access : (state_q != StDone);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_fault_MEM = misalign_q;
    assign load_data_MEM      = misalign_q ? '0 : load_data_q;
`else
    assign load_data_MEM      = load_data_q;
`endif

endmodule
